// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the two-requester memory port arbiter:
//   - sequencer state enum (IDLE, ACCESS, RESP)
//   - memory region codes taken from the top two word-address bits
//   - default data/address widths
package mem_arb_pkg;

  localparam int DATA_SIZE_DEF    = 16;
  localparam int ADDRESS_SIZE_DEF = 12;

  localparam logic [1:0] REGION_CODE = 2'b00;
  localparam logic [1:0] REGION_IO   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  function automatic logic is_code_region(input logic [1:0] region);
    return region == REGION_CODE;
  endfunction

endpackage

// File: rtl/arb2_select.sv
// arb2_select
// Two-input grant selector with a one-bit priority pointer.
// Build option: MEM_ARB_ROUND_ROBIN_EN
//   defined   - pointer moves to the requester not granted last (alternation)
//   undefined - pointer stays on requester 0 (fixed priority)
// Ports:
//   clk, reset  - clock, synchronous active-high reset (pointer -> requester 0)
//   req[1:0]    - request vector
//   advance     - a grant is being taken this edge; update the pointer
//   any         - at least one request is high
//   winner      - id of the selected requester (valid when any = 1)
module arb2_select (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       any,
  output logic       winner
);

  logic ptr_q, ptr_d;

  always_comb begin
    any    = req[0] | req[1];
    // Contention goes to the pointer; a lone request wins outright.
    winner = (req == 2'b11) ? ptr_q : req[1];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ptr_d  = advance ? ~winner : ptr_q;
`else
    // Pointer never leaves requester 0 (its reset value).
    ptr_d  = ptr_q & ~advance;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between requester 0 (CPU) and requester 1 (DMA /
// display). A three-state sequencer (IDLE -> ACCESS -> RESP) serialises
// accesses and covers the memory's one-cycle registered read latency.
// Writes into the code region (addr[11:10] = 2'b00) are suppressed and
// flagged on wr_fault; the access still completes with gnt and rvalid.
// Build option: MEM_ARB_ROUND_ROBIN_EN (see arb2_select).
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   reqN, weN, addrN, wdataN     - requester N access (req held until gntN)
//   gntN                         - pulse in the ACCESS cycle of requester N
//   rvalidN, rdata               - pulse / data in the RESP cycle
//   wr_fault                     - pulse when a code-region write is blocked
//   mem_addr, mem_wdata, mem_we  - to memory port A
//   mem_rdata                    - from memory port A (registered in memory)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_SIZE    = DATA_SIZE_DEF,
  parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [ADDRESS_SIZE-1:0] addr0,
  input  logic [ADDRESS_SIZE-1:0] addr1,
  input  logic [DATA_SIZE-1:0]    wdata0,
  input  logic [DATA_SIZE-1:0]    wdata1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    rvalid0,
  output logic                    rvalid1,
  output logic [DATA_SIZE-1:0]    rdata,
  output logic                    wr_fault,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0]    mem_wdata,
  output logic                    mem_we,
  input  logic [DATA_SIZE-1:0]    mem_rdata
);

  arb_state_e              state_q, state_d;
  logic                    id_q, id_d;
  logic                    we_q, we_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0]    wdata_q, wdata_d;

  logic arb_any, arb_winner, take;

  // Arbitration happens on the IDLE edge and on the RESP edge; requests
  // seen while in ACCESS are ignored.
  assign take = (state_q != ACCESS) && arb_any;

  arb2_select u_select (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1, req0}),
    .advance (take),
    .any     (arb_any),
    .winner  (arb_winner)
  );

  // State register (latched request fields included).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state and latch update.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE:    state_d = take ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      RESP:    state_d = take ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
    // Latches only move when entering ACCESS, so mem_addr/mem_wdata hold
    // their last values in every other cycle.
    if (take) begin
      id_d    = arb_winner;
      we_d    = arb_winner ? we1    : we0;
      addr_d  = arb_winner ? addr1  : addr0;
      wdata_d = arb_winner ? wdata1 : wdata0;
    end
  end

  // Outputs: decodes of registered state and latched fields.
  always_comb begin
    logic in_access, in_resp, code_hit;
    in_access = (state_q == ACCESS);
    in_resp   = (state_q == RESP);
    code_hit  = is_code_region(addr_q[ADDRESS_SIZE-1 -: 2]);
    gnt0      = in_access & ~id_q;
    gnt1      = in_access &  id_q;
    rvalid0   = in_resp   & ~id_q;
    rvalid1   = in_resp   &  id_q;
    mem_we    = in_access & we_q & ~code_hit;
    wr_fault  = in_access & we_q &  code_hit;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    rdata     = in_resp ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 12;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, wr_fault, mem_we;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;
  int last_gnt = 1;  // "not granted last" after reset is requester 0

  logic [DW-1:0] mem    [0:4095];
  logic [DW-1:0] shadow [0:4095];

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .wr_fault(wr_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Memory with registered read (read-before-write).
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_code(input logic [AW-1:0] a);
    return a[11:10] == 2'b00;
  endfunction

  function automatic int pick(input bit r0, input bit r1, input int last);
    if (RR && r0 && r1) return (last == 0) ? 1 : 0;
    return r0 ? 0 : 1;
  endfunction

  task automatic check_quiet(input string tag);
    check(tag, {gnt0, gnt1, rvalid0, rvalid1, mem_we, wr_fault}, 6'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_quiet(tag);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_rdata"}, rdata, 0);
  endtask

  // One isolated access from IDLE; expected values from the shadow memory.
  task automatic xact(input int id, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] old;
    bit code;
    code = is_code(a);
    old  = shadow[a];
    if (id == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    else         begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    tick();
    check("x_gnt", {gnt1, gnt0}, (id == 0) ? 2'b01 : 2'b10);
    check("x_rvalid_early", {rvalid1, rvalid0}, 0);
    check("x_mem_addr", mem_addr, a);
    if (we) check("x_mem_wdata", mem_wdata, d);
    check("x_mem_we", mem_we, we && !code);
    check("x_wr_fault", wr_fault, we && code);
    req0 = 0; req1 = 0;
    tick();
    check("x_rvalid", {rvalid1, rvalid0}, (id == 0) ? 2'b01 : 2'b10);
    check("x_resp_quiet", {gnt1, gnt0, mem_we, wr_fault}, 0);
    if (!we || code) check("x_rdata", rdata, old);
    if (we && !code) shadow[a] = d;
    last_gnt = id;
    tick();
    check_quiet("x_idle");
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = 16'($urandom);
      shadow[i] = mem[i];
    end
    mem[12'h400] = 16'hBEEF; shadow[12'h400] = 16'hBEEF;

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    reset = 0;
    tick();
    check_all_zero("post_reset");

    // Directed accesses
    xact(0, 0, 12'h400, 16'h0);
    check("beef_model", shadow[12'h400], 16'hBEEF);
    xact(1, 1, 12'h800, 16'h1234);
    xact(1, 0, 12'h800, 16'h0);
    check("w800_mem", mem[12'h800], 16'h1234);
    xact(0, 1, 12'h010, 16'hFFFF);
    xact(0, 0, 12'h010, 16'h0);
    xact(1, 1, 12'hFFF, 16'h02AA);
    check("led_mem", mem[12'hFFF], 16'h02AA);

    // Reset during ACCESS of a write: write already issued, no rvalid
    req0 = 1; we0 = 1; addr0 = 12'h500; wdata0 = 16'h5555;
    tick();
    check("rstacc_gnt", {gnt0, mem_we}, 2'b11);
    reset = 1; req0 = 0;
    tick();
    check_all_zero("rstacc_out");
    shadow[12'h500] = 16'h5555;
    reset = 0; last_gnt = 1;
    tick();
    check_quiet("rstacc_norv");
    tick();
    check_quiet("rstacc_idle");

    // Reset at the sampling edge: write never issued
    req0 = 1; we0 = 1; addr0 = 12'h500; wdata0 = 16'hAAAA; reset = 1;
    tick();
    check_all_zero("rstsmp_out");
    req0 = 0; reset = 0;
    tick();
    check_quiet("rstsmp_q1");
    tick();
    check_quiet("rstsmp_q2");
    xact(0, 0, 12'h500, 16'h0);
    check("rstsmp_mem", mem[12'h500], 16'h5555);

    // Both requesters held high over four transactions
    reset = 1; tick(); reset = 0; last_gnt = 1;
    req0 = 1; we0 = 0; addr0 = 12'h400;
    req1 = 1; we1 = 0; addr1 = 12'h800;
    begin
      int got = 0;
      int prev_c = -1;
      for (int c = 0; c < 14 && got < 4; c++) begin
        tick();
        check("both_onehot", {31'b0, gnt0 & gnt1}, 0);
        if (gnt0 || gnt1) begin
          check("both_order", {31'b0, gnt1}, RR ? (got % 2) : 0);
          if (prev_c >= 0) check("both_spacing", c - prev_c, 2);
          prev_c = c;
          got++;
        end
      end
      check("both_count", got, 4);
    end
    req0 = 0; req1 = 0;
    last_gnt = RR ? 1 : 0;
    tick(); tick(); tick();
    check_quiet("both_idle");

    // Randomized traffic against a transaction-level model
    begin
      bit skip = 0;
      bit rv_now, rv_id, rv_we;
      logic [AW-1:0] rv_addr;
      logic [DW-1:0] rv_data;
      bit s0, s1;
      int g;
      bit pwe [2];
      logic [AW-1:0] pa [2];
      logic [DW-1:0] pd [2];
      rv_id = 0; rv_we = 0; rv_addr = '0; rv_data = '0;
      for (int c = 0; c < 600; c++) begin
        for (int i = 0; i < 2; i++) begin
          if (((i == 0) ? req0 : req1) == 1'b0 && $urandom_range(0, 1) == 1) begin
            logic [AW-1:0] a;
            a        = 12'($urandom_range(0, 15));
            a[11:10] = 2'($urandom_range(0, 3));
            pa[i]  = a;
            pwe[i] = 1'($urandom_range(0, 1));
            pd[i]  = 16'($urandom);
            if (i == 0) begin req0 = 1; we0 = pwe[0]; addr0 = pa[0]; wdata0 = pd[0]; end
            else        begin req1 = 1; we1 = pwe[1]; addr1 = pa[1]; wdata1 = pd[1]; end
          end
        end
        s0 = req0; s1 = req1;
        tick();
        g = -1; rv_now = 0;
        if (skip) begin
          skip = 0; rv_now = 1;
        end else if (s0 || s1) begin
          g = pick(s0, s1, last_gnt);
          last_gnt = g; skip = 1;
        end
        check("r_gnt", {gnt1, gnt0}, (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10));
        if (g >= 0) begin
          check("r_mem_addr", mem_addr, pa[g]);
          if (pwe[g]) check("r_mem_wdata", mem_wdata, pd[g]);
          check("r_mem_we", mem_we, pwe[g] && !is_code(pa[g]));
          check("r_wr_fault", wr_fault, pwe[g] && is_code(pa[g]));
          rv_id = g[0]; rv_we = pwe[g]; rv_addr = pa[g]; rv_data = pd[g];
          if (g == 0) req0 = 0; else req1 = 0;
        end else begin
          check("r_we_idle", {mem_we, wr_fault}, 0);
        end
        if (rv_now) begin
          check("r_rvalid", {rvalid1, rvalid0}, rv_id ? 2'b10 : 2'b01);
          if (!rv_we || is_code(rv_addr)) check("r_rdata", rdata, shadow[rv_addr]);
          if (rv_we && !is_code(rv_addr)) shadow[rv_addr] = rv_data;
        end else begin
          check("r_rvalid_idle", {rvalid1, rvalid0}, 0);
        end
      end
      req0 = 0; req1 = 0;
      tick(); tick(); tick();
      check_quiet("r_end_idle");
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 16; j++)
          check("r_mem_final", mem[i * 1024 + j], shadow[i * 1024 + j]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
